// File: rtl/sel_split_pkg.sv
// Shared constants and types for the select-split stream stage.
package sel_split_pkg;

  localparam int NUM_OUT_DEF = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int CNT_W_DEF   = 16;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

  typedef logic [NUM_OUT_DEF-1:0] mask_t;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sel_split_stream.sv
// Routes one input token to any subset of NUM_OUT consumers; the token is held
// until every selected consumer has taken it, then retired.
module sel_split_stream
  import sel_split_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [NUM_OUT-1:0] i_mask,
  output logic [NUM_OUT-1:0] o_valid,
  input  logic [NUM_OUT-1:0] o_ready,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_tok_cnt,
  output logic [CNT_W-1:0]   o_drop_cnt
);

  logic [NUM_OUT-1:0] pend_q, pend_d, pend_left;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               drain, acc, zero_mask, tok_inc, drop_inc;

  // Channels still owed the token after this cycle's handshakes.
  assign pend_left = pend_q & ~o_ready;
  assign drain     = (pend_left == '0);
  assign acc       = i_valid & drain;
  assign zero_mask = (i_mask == '0);

  // Ready is combinational from o_ready so a drain and a new accept share a cycle.
  assign i_ready   = drain;

  assign tok_inc   = (pend_q != '0) & drain;
  assign drop_inc  = acc & zero_mask;

  always_comb begin
    pend_d = pend_left;
    data_d = data_q;
    if (acc) begin
      pend_d = i_mask;
      if (!zero_mask) data_d = i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

  assign o_valid = pend_q;
  assign o_data  = data_q;
  assign o_busy  = (pend_q != '0);

  sat_cnt #(.W(CNT_W)) u_tok_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (tok_inc),
    .cnt_o (o_tok_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (drop_inc),
    .cnt_o (o_drop_cnt)
  );

endmodule
